// File: rtl/ram189_arbiter_pkg.sv
// Shared types and constants for the two-requester CI74F189 RAM arbiter.
package ram189_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 4;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

endpackage

// File: rtl/ram189_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer favours whichever requester lost the last grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    // Granting requester 0 hands priority to requester 1 and vice versa.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (take) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/ram189_arbiter.sv
// Arbitrates two req/ack masters onto one 16x4 inverted-output RAM and sequences its pins.
module ram189_arbiter
    import ram189_pkg::*;
#(
    parameter int ACC_CYC = 1,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_cs_n,
    output logic              ram_we_n,
    input  logic [DATA_W-1:0] ram_o
);

    localparam int CNT_W = $clog2(ACC_CYC + 1);

    state_t             state;
    state_t             state_n;
    logic               take;
    logic [1:0]         gnt;
    logic               sel;
    logic               op;
    logic [CNT_W-1:0]   cnt;
    logic               cs_n_nx;
    logic               we_n_nx;

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({req1, req0}),
        .take (take),
        .gnt  (gnt)
    );

    // Pin levels are computed from the next state and registered, so they never glitch.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_n = SETUP;
                    take    = 1'b1;
                end
            end
            SETUP:   state_n = ACCESS;
            ACCESS:  if (cnt == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        cs_n_nx = (state_n != ACCESS);
        we_n_nx = !((state_n == ACCESS) && (op == OP_WR));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
            op       <= OP_RD;
            cnt      <= '0;
            ram_a    <= '0;
            ram_d    <= '0;
            ram_cs_n <= 1'b1;
            ram_we_n <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state    <= state_n;
            ram_cs_n <= cs_n_nx;
            ram_we_n <= we_n_nx;
            ack0     <= (state_n == DONE) && !sel;
            ack1     <= (state_n == DONE) && sel;
            if (take) begin
                sel   <= gnt[1];
                op    <= gnt[1] ? wr1 : wr0;
                ram_a <= gnt[1] ? addr1 : addr0;
                ram_d <= gnt[1] ? wdata1 : wdata0;
            end
            if (state == SETUP) begin
                cnt <= CNT_W'(ACC_CYC - 1);
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            // The RAM output is inverted; only the granted requester's rdata moves.
            if ((state == ACCESS) && (cnt == '0) && (op == OP_RD)) begin
                if (sel) begin
                    rdata1 <= ~ram_o;
                end else begin
                    rdata0 <= ~ram_o;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram189_arbiter.sv
// Directed bench: one arbiter with ACC_CYC=1 and one with ACC_CYC=3, each with its own RAM model.
module tb_ram189_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic       a_req0 = 0, a_wr0 = 0, a_req1 = 0, a_wr1 = 0;
    logic [3:0] a_addr0 = 0, a_wdata0 = 0, a_addr1 = 0, a_wdata1 = 0;
    logic       a_ack0, a_ack1, a_ram_cs_n, a_ram_we_n;
    logic [3:0] a_rdata0, a_rdata1, a_ram_a, a_ram_d;
    wire  [3:0] a_ram_o;
    logic [3:0] a_mem [16];

    logic       b_req0 = 0, b_wr0 = 0;
    logic [3:0] b_addr0 = 0, b_wdata0 = 0;
    logic       b_ack0, b_ack1, b_ram_cs_n, b_ram_we_n;
    logic [3:0] b_rdata0, b_rdata1, b_ram_a, b_ram_d;
    wire  [3:0] b_ram_o;
    logic [3:0] b_mem [16];
    int         b_cs_run = 0;

    ram189_arbiter #(.ACC_CYC(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0(a_req0), .wr0(a_wr0), .addr0(a_addr0), .wdata0(a_wdata0), .ack0(a_ack0), .rdata0(a_rdata0),
        .req1(a_req1), .wr1(a_wr1), .addr1(a_addr1), .wdata1(a_wdata1), .ack1(a_ack1), .rdata1(a_rdata1),
        .ram_a(a_ram_a), .ram_d(a_ram_d), .ram_cs_n(a_ram_cs_n), .ram_we_n(a_ram_we_n), .ram_o(a_ram_o)
    );

    ram189_arbiter #(.ACC_CYC(3)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .wr0(b_wr0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
        .req1(1'b0), .wr1(1'b0), .addr1(4'h0), .wdata1(4'h0), .ack1(b_ack1), .rdata1(b_rdata1),
        .ram_a(b_ram_a), .ram_d(b_ram_d), .ram_cs_n(b_ram_cs_n), .ram_we_n(b_ram_we_n), .ram_o(b_ram_o)
    );

    // RAM models: write on cs_n=0 & we_n=0, inverted output while reading, high-Z otherwise.
    always @(posedge clk) begin
        if (!a_ram_cs_n && !a_ram_we_n) a_mem[a_ram_a] <= a_ram_d;
        if (!b_ram_cs_n && !b_ram_we_n) b_mem[b_ram_a] <= b_ram_d;
        b_cs_run <= b_ram_cs_n ? 0 : b_cs_run + 1;
    end
    assign a_ram_o = (!a_ram_cs_n && a_ram_we_n) ? ~a_mem[a_ram_a] : 4'bz;
    // Slow part: data only valid once select has been low for two edges.
    assign b_ram_o = (!b_ram_cs_n && b_ram_we_n) ? ((b_cs_run >= 2) ? ~b_mem[b_ram_a] : 4'h0) : 4'bz;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic wr, input logic [3:0] addr, input logic [3:0] data);
        if (which == 0) begin
            a_req0 = 1'b1; a_wr0 = wr; a_addr0 = addr; a_wdata0 = data;
        end else begin
            a_req1 = 1'b1; a_wr1 = wr; a_addr1 = addr; a_wdata1 = data;
        end
    endtask

    // Runs dut_a until all pending requests are acked; tick index of each ack is returned.
    task automatic runA(output int t0, output int t1, output int cslow, output int welow);
        t0 = -1; t1 = -1; cslow = 0; welow = 0;
        for (int i = 1; i <= 30; i++) begin
            if (!a_req0 && !a_req1) break;
            tick;
            if (!a_ram_cs_n) cslow++;
            if (!a_ram_we_n) welow++;
            if (a_ack0) begin t0 = i; a_req0 = 1'b0; end
            if (a_ack1) begin t1 = i; a_req1 = 1'b0; end
        end
        a_req0 = 1'b0;
        a_req1 = 1'b0;
        tick;
    endtask

    task automatic runB(output int t0, output int cslow, output int welow);
        t0 = -1; cslow = 0; welow = 0;
        for (int i = 1; i <= 30; i++) begin
            if (!b_req0) break;
            tick;
            if (!b_ram_cs_n) cslow++;
            if (!b_ram_we_n) welow++;
            if (b_ack0) begin t0 = i; b_req0 = 1'b0; end
        end
        b_req0 = 1'b0;
        tick;
    endtask

    initial begin
        int t0, t1, cslow, welow;
        logic [16:0] ack0_seen, ack1_seen;
        logic ack_any;

        // Reset and idle.
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            checkOutput("idle_a", {a_ram_cs_n, a_ram_we_n, a_ram_a, a_ack0, a_ack1, a_rdata0, a_rdata1},
                        {1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0});
        end
        checkOutput("idle_b", {b_ram_cs_n, b_ram_we_n, b_ram_a, b_ack0, b_rdata0}, {1'b1, 1'b1, 4'h0, 1'b0, 4'h0});

        // Write then read address 5 from requester 0.
        applyStimulus(0, 1'b1, 4'h5, 4'hA);
        runA(t0, t1, cslow, welow);
        checkOutput("wr5_lat", t0, 3);
        checkOutput("wr5_we_low", welow, 1);
        checkOutput("wr5_rdata_kept", a_rdata0, 4'h0);
        applyStimulus(0, 1'b0, 4'h5, 4'h0);
        runA(t0, t1, cslow, welow);
        checkOutput("rd5_lat", t0, 3);
        checkOutput("rd5_cs_low", cslow, 1);
        checkOutput("rd5_we_low", welow, 0);
        checkOutput("rd5_data", a_rdata0, 4'hA);

        // Contention: pointer back at requester 0 after reset.
        rst = 1'b1; tick; rst = 1'b0; tick;
        applyStimulus(0, 1'b1, 4'h0, 4'h3);
        applyStimulus(1, 1'b1, 4'hF, 4'hC);
        runA(t0, t1, cslow, welow);
        checkOutput("pair_wr_ack0", t0, 3);
        checkOutput("pair_wr_ack1", t1, 7);
        applyStimulus(0, 1'b0, 4'hF, 4'h0);
        runA(t0, t1, cslow, welow);
        checkOutput("rd15_r0", a_rdata0, 4'hC);
        checkOutput("rd15_r1_kept", a_rdata1, 4'h0);
        applyStimulus(0, 1'b0, 4'h0, 4'h0);
        applyStimulus(1, 1'b0, 4'hF, 4'h0);
        runA(t0, t1, cslow, welow);
        checkOutput("pair_rd_ack1", t1, 3);
        checkOutput("pair_rd_ack0", t0, 7);
        checkOutput("pair_rd_r1", a_rdata1, 4'hC);
        checkOutput("pair_rd_r0", a_rdata0, 4'h3);

        // ACC_CYC=3 instance: write then read address 9.
        b_req0 = 1'b1; b_wr0 = 1'b1; b_addr0 = 4'h9; b_wdata0 = 4'h6;
        runB(t0, cslow, welow);
        checkOutput("b_wr_lat", t0, 5);
        checkOutput("b_wr_we_low", welow, 3);
        b_req0 = 1'b1; b_wr0 = 1'b0;
        runB(t0, cslow, welow);
        checkOutput("b_rd_lat", t0, 5);
        checkOutput("b_rd_cs_low", cslow, 3);
        checkOutput("b_rd_we_low", welow, 0);
        checkOutput("b_rd_data", b_rdata0, 4'h6);

        // Reset in the middle of a requester 1 write.
        applyStimulus(1, 1'b1, 4'h7, 4'h9);
        tick; tick;
        checkOutput("mid_access_pins", {a_ram_cs_n, a_ram_we_n}, 2'b00);
        rst = 1'b1; a_req1 = 1'b0;
        tick;
        checkOutput("rst_pins", {a_ram_cs_n, a_ram_we_n, a_ack0, a_ack1, a_ram_a, a_ram_d, a_rdata0, a_rdata1},
                    {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0});
        rst = 1'b0;
        ack_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            ack_any = ack_any | a_ack1 | a_ack0;
        end
        checkOutput("rst_no_ack", ack_any, 1'b0);
        applyStimulus(0, 1'b0, 4'hF, 4'h0);
        applyStimulus(1, 1'b1, 4'h7, 4'h9);
        runA(t0, t1, cslow, welow);
        checkOutput("reissue_ack0", t0, 3);
        checkOutput("reissue_ack1", t1, 7);
        checkOutput("reissue_r0", a_rdata0, 4'hC);
        applyStimulus(1, 1'b0, 4'h7, 4'h0);
        runA(t0, t1, cslow, welow);
        checkOutput("readback7_lat", t1, 3);
        checkOutput("readback7_r1", a_rdata1, 4'h9);

        // Requester 1 streams; requester 0 joins during its second access.
        ack0_seen = '0;
        ack1_seen = '0;
        applyStimulus(1, 1'b0, 4'h7, 4'h0);
        for (int i = 1; i <= 16; i++) begin
            tick;
            ack0_seen[i] = a_ack0;
            ack1_seen[i] = a_ack1;
            if (a_ack0) a_req0 = 1'b0;
            if (i == 6) applyStimulus(0, 1'b0, 4'h0, 4'h0);
        end
        a_req1 = 1'b0;
        tick; tick; tick; tick; tick;
        checkOutput("stream_ack1", ack1_seen, 17'h08088);
        checkOutput("stream_ack0", ack0_seen, 17'h00800);
        checkOutput("stream_r0", a_rdata0, 4'h3);
        checkOutput("stream_r1", a_rdata1, 4'h9);
        checkOutput("stream_idle", {a_ram_cs_n, a_ram_we_n, a_ack0, a_ack1}, 4'b1100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
